// File: rtl/oldland_tlb.sv
// Fully-associative, software-managed TLB with 4 KiB pages and round-robin refill.
// One lookup per cycle. Results are registered, so they appear one cycle after the request.
module oldland_tlb #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    input  logic        translate,
    input  logic [31:0] virt,
    output logic [31:0] phys,
    output logic [1:0]  access,
    output logic        complete,
    output logic        hit,
    output logic        miss,
    output logic        miss_pending,
    output logic [19:0] miss_virt,
    input  logic        inval,
    input  logic        load,
    input  logic [19:0] load_virt,
    input  logic [19:0] load_phys,
    input  logic [1:0]  load_access
);
    localparam int IDXW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [19:0]        vpage_q [ENTRIES];
    logic [19:0]        ppage_q [ENTRIES];
    logic [1:0]         acc_q   [ENTRIES];
    logic [IDXW-1:0]    victim_q;

    logic [31:0] phys_q,     phys_d;
    logic [1:0]  access_q,   access_d;
    logic        complete_q, complete_d;
    logic        hit_q,      hit_d;
    logic        miss_q,     miss_d;
    logic        pend_q,     pend_d;
    logic [19:0] mvirt_q,    mvirt_d;

    logic            lk_hit;
    logic [IDXW-1:0] lk_idx;
    logic            ld_hit;
    logic [IDXW-1:0] ld_idx;

    // The first match in ascending order wins, so the lowest index takes priority on duplicates.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        ld_hit = 1'b0;
        ld_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!lk_hit && valid_q[i] && vpage_q[i] == virt[31:12]) begin
                lk_hit = 1'b1;
                lk_idx = IDXW'(i);
            end
            if (!ld_hit && valid_q[i] && vpage_q[i] == load_virt) begin
                ld_hit = 1'b1;
                ld_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        phys_d     = phys_q;
        access_d   = access_q;
        complete_d = translate;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        pend_d     = pend_q;
        mvirt_d    = mvirt_q;
        if (translate) begin
            if (!enabled) begin
                phys_d   = virt;
                access_d = 2'b11;
                hit_d    = 1'b1;
            end else if (lk_hit) begin
                phys_d   = {ppage_q[lk_idx], virt[11:0]};
                access_d = acc_q[lk_idx];
                hit_d    = 1'b1;
            end else begin
                phys_d   = '0;
                access_d = '0;
                miss_d   = 1'b1;
            end
        end
        if (inval || load)
            pend_d = 1'b0;
        // A fresh fault outranks a refill or flush arriving in the same cycle.
        if (miss_d) begin
            pend_d  = 1'b1;
            mvirt_d = virt[31:12];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phys_q     <= '0;
            access_q   <= '0;
            complete_q <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            pend_q     <= 1'b0;
            mvirt_q    <= '0;
        end else begin
            phys_q     <= phys_d;
            access_q   <= access_d;
            complete_q <= complete_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            pend_q     <= pend_d;
            mvirt_q    <= mvirt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            victim_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                vpage_q[i] <= '0;
                ppage_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else if (inval) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else if (load) begin
            if (ld_hit) begin
                ppage_q[ld_idx] <= load_phys;
                acc_q[ld_idx]   <= load_access;
            end else begin
                valid_q[victim_q] <= 1'b1;
                vpage_q[victim_q] <= load_virt;
                ppage_q[victim_q] <= load_phys;
                acc_q[victim_q]   <= load_access;
                victim_q          <= victim_q + IDXW'(1);
            end
        end
    end

    assign phys         = phys_q;
    assign access       = access_q;
    assign complete     = complete_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign miss_pending = pend_q;
    assign miss_virt    = mvirt_q;

endmodule

// File: tb/tb_oldland_tlb.sv
// Self-checking bench for oldland_tlb: directed scenarios plus a randomized mix,
// all compared against a page-table reference model kept in the bench.
module tb_oldland_tlb;
    localparam int ENTRIES = 8;

    logic        clk = 1'b0;
    logic        rst, enabled, translate, inval, load;
    logic [31:0] virt, phys;
    logic [1:0]  access, load_access;
    logic        complete, hit, miss, miss_pending;
    logic [19:0] miss_virt, load_virt, load_phys;

    always #5 clk = ~clk;

    oldland_tlb #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .enabled(enabled), .translate(translate), .virt(virt),
        .phys(phys), .access(access), .complete(complete), .hit(hit), .miss(miss),
        .miss_pending(miss_pending), .miss_virt(miss_virt), .inval(inval), .load(load),
        .load_virt(load_virt), .load_phys(load_phys), .load_access(load_access)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a small page table with a round-robin refill slot.
    bit          m_valid [ENTRIES];
    logic [19:0] m_vp    [ENTRIES];
    logic [19:0] m_pp    [ENTRIES];
    logic [1:0]  m_ac    [ENTRIES];
    int          m_ptr;
    logic        m_pend;
    logic [19:0] m_mvirt;
    logic [31:0] e_phys;
    logic [1:0]  e_acc;
    logic        e_cmp, e_hit, e_miss;

    logic [57:0] obs, expv;
    assign obs = {phys, access, complete, hit, miss, miss_pending, miss_virt};

    task automatic step(input logic r, input logic tr, input logic en, input logic [31:0] va,
                        input logic ld, input logic [19:0] lv, input logic [19:0] lp,
                        input logic [1:0] la, input logic iv);
        int idx;
        int j;
        @(negedge clk);
        rst = r; translate = tr; enabled = en; virt = va;
        load = ld; load_virt = lv; load_phys = lp; load_access = la; inval = iv;
        if (r) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_vp[i] = '0; m_pp[i] = '0; m_ac[i] = '0;
            end
            m_ptr = 0; m_pend = 0; m_mvirt = '0;
            e_phys = '0; e_acc = '0; e_cmp = 0; e_hit = 0; e_miss = 0;
        end else begin
            e_cmp = tr; e_hit = 0; e_miss = 0;
            if (tr) begin
                if (!en) begin
                    e_hit = 1; e_phys = va; e_acc = 2'b11;
                end else begin
                    idx = -1;
                    for (int i = 0; i < ENTRIES; i++)
                        if (idx < 0 && m_valid[i] && m_vp[i] == va[31:12]) idx = i;
                    if (idx >= 0) begin
                        e_hit = 1; e_phys = {m_pp[idx], va[11:0]}; e_acc = m_ac[idx];
                    end else begin
                        e_miss = 1; e_phys = '0; e_acc = '0;
                    end
                end
            end
            if (iv) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
                m_ptr = 0; m_pend = 0;
            end else if (ld) begin
                j = -1;
                for (int i = 0; i < ENTRIES; i++)
                    if (j < 0 && m_valid[i] && m_vp[i] == lv) j = i;
                if (j >= 0) begin
                    m_pp[j] = lp; m_ac[j] = la;
                end else begin
                    m_valid[m_ptr] = 1; m_vp[m_ptr] = lv; m_pp[m_ptr] = lp; m_ac[m_ptr] = la;
                    m_ptr = (m_ptr + 1) % ENTRIES;
                end
                m_pend = 0;
            end
            if (e_miss) begin
                m_pend = 1; m_mvirt = va[31:12];
            end
        end
        expv = {e_phys, e_acc, e_cmp, e_hit, e_miss, m_pend, m_mvirt};
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [19:0] lv, input logic [19:0] lp, input logic [1:0] la);
        step(0, 0, 1, '0, 1, lv, lp, la, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 1, '0, 0, '0, '0, '0, 0);
        step(1, 1, 1, 32'h1234_5678, 1, 20'h12345, 20'hABCDE, 2'b10, 1);
        checks++;
        if (obs !== 58'h0) begin
            failures++;
            $display("FAIL reset_state observed=%h required=%h", obs, 58'h0);
        end
    endtask

    task automatic test_miss_then_load();
        step(0, 1, 1, 32'h0040_1234, 0, '0, '0, '0, 0);
        checks++;
        if ({complete, miss, hit, phys, miss_pending, miss_virt} !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 20'h00401}) begin
            failures++;
            $display("FAIL first_miss observed c=%b m=%b h=%b phys=%h mp=%b mv=%h required 1 1 0 00000000 1 00401",
                     complete, miss, hit, phys, miss_pending, miss_virt);
        end
        do_load(20'h00401, 20'h80002, 2'b01);
        step(0, 1, 1, 32'h0040_1234, 0, '0, '0, '0, 0);
        checks++;
        if ({complete, hit, miss, phys, access, miss_pending} !== {1'b1, 1'b1, 1'b0, 32'h8000_2234, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL refill_hit observed c=%b h=%b m=%b phys=%h acc=%b mp=%b required 1 1 0 80002234 01 0",
                     complete, hit, miss, phys, access, miss_pending);
        end
    endtask

    task automatic test_eviction();
        step(0, 0, 1, '0, 0, '0, '0, '0, 1);
        for (int p = 0; p <= ENTRIES; p++) do_load(20'(p), 20'(32'h40000 + p), 2'(p));
        for (int p = 0; p <= ENTRIES; p++) begin
            step(0, 1, 1, {20'(p), 12'h5A5}, 0, '0, '0, '0, 0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL evict_page%0d observed=%h required=%h", p, obs, expv);
            end
        end
        checks++;
        if (m_ptr != 1 || dut.victim_q !== 3'd1) begin
            failures++;
            $display("FAIL victim_after_wrap observed=%0d required=1", dut.victim_q);
        end
    endtask

    task automatic test_reload();
        do_load(20'h00401, 20'h80002, 2'b01);
        do_load(20'h00401, 20'h90000, 2'b10);
        step(0, 1, 1, 32'h0040_1FFC, 0, '0, '0, '0, 0);
        checks++;
        if ({hit, phys, access} !== {1'b1, 32'h9000_0FFC, 2'b10} || obs !== expv) begin
            failures++;
            $display("FAIL reload_overwrite observed=%h required=%h", obs, expv);
        end
        for (int p = 2; p <= ENTRIES; p++) begin
            step(0, 1, 1, {20'(p), 12'h001}, 0, '0, '0, '0, 0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reload_keep_page%0d observed=%h required=%h", p, obs, expv);
            end
        end
    endtask

    task automatic test_inval_and_disabled();
        step(0, 0, 1, '0, 1, 20'h00777, 20'h11111, 2'b01, 1);
        step(0, 1, 1, 32'h0077_7000, 0, '0, '0, '0, 0);
        checks++;
        if ({miss, hit} !== 2'b10 || obs !== expv) begin
            failures++;
            $display("FAIL inval_beats_load observed=%h required=%h", obs, expv);
        end
        step(0, 1, 0, 32'hDEAD_BEEF, 0, '0, '0, '0, 0);
        checks++;
        if ({hit, miss, phys, access, miss_pending, miss_virt} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 2'b11, 1'b1, 20'h00777}) begin
            failures++;
            $display("FAIL disabled_identity observed=%h required h=1 m=0 phys=deadbeef acc=11 mp=1 mv=00777", obs);
        end
        step(0, 0, 1, 32'h0000_1000, 0, '0, '0, '0, 0);
        checks++;
        if ({complete, hit, miss, phys, access} !== {3'b000, 32'hDEAD_BEEF, 2'b11}) begin
            failures++;
            $display("FAIL idle_hold observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_miss_with_load();
        do_load(20'h00123, 20'h00456, 2'b01);
        step(0, 1, 1, 32'h0099_9000, 1, 20'h00999, 20'h00888, 2'b10, 0);
        checks++;
        if ({miss, miss_pending, miss_virt} !== {1'b1, 1'b1, 20'h00999} || obs !== expv) begin
            failures++;
            $display("FAIL miss_beats_load observed=%h required=%h", obs, expv);
        end
    endtask

    task automatic test_random();
        logic tr, en, ld, iv;
        for (int n = 0; n < 400; n++) begin
            tr = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 7) != 0);
            ld = ($urandom_range(0, 2) == 0);
            iv = ($urandom_range(0, 19) == 0);
            if (iv) tr = 1'b0;
            step(0, tr, en, {20'($urandom_range(0, 11)), 12'($urandom)}, ld,
                 20'($urandom_range(0, 11)), 20'($urandom), 2'($urandom), iv);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL random_cycle%0d observed=%h required=%h", n, obs, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1, '0, 0, '0, '0, '0, 1);
        do_load(20'h00010, 20'h00AAA, 2'b01);
        do_load(20'h00020, 20'h00BBB, 2'b10);
        for (int n = 0; n < 4; n++) begin
            step(0, 1, 1, {20'(16 * (n + 1)), 12'(n * 12'h111)}, 0, '0, '0, '0, 0);
            checks++;
            if (complete !== 1'b1 || obs !== expv) begin
                failures++;
                $display("FAIL b2b_cycle%0d observed=%h required=%h", n, obs, expv);
            end
        end
        step(1, 1, 1, 32'h0001_0000, 0, '0, '0, '0, 0);
        for (int n = 0; n < 2; n++) begin
            step(0, 0, 1, 32'h0001_0000, 0, '0, '0, '0, 0);
            checks++;
            if (obs !== 58'h0) begin
                failures++;
                $display("FAIL b2b_after_reset%0d observed=%h required=0", n, obs);
            end
        end
        step(0, 1, 1, 32'h0001_0004, 0, '0, '0, '0, 0);
        checks++;
        if ({miss, hit, miss_virt} !== {2'b10, 20'h00010} || obs !== expv) begin
            failures++;
            $display("FAIL entries_cleared_by_reset observed=%h required=%h", obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; enabled = 1'b0; translate = 1'b0; virt = '0; inval = 1'b0;
        load = 1'b0; load_virt = '0; load_phys = '0; load_access = '0;
        test_reset();
        test_miss_then_load();
        test_eviction();
        test_reload();
        test_inval_and_disabled();
        test_miss_with_load();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
